// File: rtl/morse_tx.sv
// Morse transmitter for letters A..H: one-hot FSM paced by a unit prescaler.
// Define MORSE_TX_QUEUE_EN to add a one-entry pending request captured while busy.
module morse_tx #(
  parameter int unsigned TICKS_PER_UNIT = 4,
  parameter int unsigned DOT_UNITS      = 1,
  parameter int unsigned DASH_UNITS     = 3,
  parameter int unsigned SYM_GAP_UNITS  = 1,
  parameter int unsigned LTR_GAP_UNITS  = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] code,
  output logic       outs,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_MK = (DOT_UNITS > DASH_UNITS) ? DOT_UNITS : DASH_UNITS;
  localparam int unsigned MAX_GP = (SYM_GAP_UNITS > LTR_GAP_UNITS) ? SYM_GAP_UNITS : LTR_GAP_UNITS;
  localparam int unsigned MAX_U  = (MAX_MK > MAX_GP) ? MAX_MK : MAX_GP;
  localparam int unsigned UW     = (MAX_U > 1) ? $clog2(MAX_U) : 1;
  localparam int unsigned PW     = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int unsigned CW     = 3;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    MARK  = 4'b0010,
    SPACE = 4'b0100,
    LGAP  = 4'b1000
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [3:0]    pat_q, pat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          outs_q, outs_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          launch_c;
  logic [2:0]    lcode_c;
  logic [3:0]    lut_pat_c;
  logic [CW-1:0] lut_cnt_c;
  logic          tick_c;
  logic          phase_end_c;
  logic [UW-1:0] last_unit_c;

`ifdef MORSE_TX_QUEUE_EN
  logic       pend_vld_q, pend_vld_d;
  logic [2:0] pend_code_q, pend_code_d;

  // A fresh start in IDLE is newer than any pending entry, so it takes priority.
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_code_d = pend_code_q;
    launch_c    = 1'b0;
    lcode_c     = code;
    if (state_q == IDLE) begin
      launch_c   = start | pend_vld_q;
      lcode_c    = start ? code : pend_code_q;
      pend_vld_d = 1'b0;
    end else if (start) begin
      pend_vld_d  = 1'b1;
      pend_code_d = code;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      pend_vld_q  <= 1'b0;
      pend_code_q <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_code_q <= pend_code_d;
    end
  end
`else
  always_comb begin
    launch_c = start & (state_q == IDLE);
    lcode_c  = code;
  end
`endif

  // Letter table: elements MSB-first, 1 = dash.
  always_comb begin
    lut_pat_c = 4'b0000;
    lut_cnt_c = CW'(1);
    unique case (lcode_c)
      3'd0: begin lut_pat_c = 4'b0100; lut_cnt_c = CW'(2); end
      3'd1: begin lut_pat_c = 4'b1000; lut_cnt_c = CW'(4); end
      3'd2: begin lut_pat_c = 4'b1010; lut_cnt_c = CW'(4); end
      3'd3: begin lut_pat_c = 4'b1000; lut_cnt_c = CW'(3); end
      3'd4: begin lut_pat_c = 4'b0000; lut_cnt_c = CW'(1); end
      3'd5: begin lut_pat_c = 4'b0010; lut_cnt_c = CW'(4); end
      3'd6: begin lut_pat_c = 4'b1100; lut_cnt_c = CW'(3); end
      3'd7: begin lut_pat_c = 4'b0000; lut_cnt_c = CW'(4); end
      default: ;
    endcase
  end

  always_comb begin
    tick_c = (ps_q == PW'(TICKS_PER_UNIT - 1));
    unique case (state_q)
      MARK:    last_unit_c = pat_q[3] ? UW'(DASH_UNITS - 1) : UW'(DOT_UNITS - 1);
      SPACE:   last_unit_c = UW'(SYM_GAP_UNITS - 1);
      LGAP:    last_unit_c = UW'(LTR_GAP_UNITS - 1);
      default: last_unit_c = '0;
    endcase
    phase_end_c = tick_c && (unit_q == last_unit_c);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    unit_d  = unit_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      if (phase_end_c) begin
        ps_d   = '0;
        unit_d = '0;
      end else if (tick_c) begin
        ps_d   = '0;
        unit_d = unit_q + UW'(1);
      end else begin
        ps_d   = ps_q + PW'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (launch_c) begin
          state_d = MARK;
          pat_d   = lut_pat_c;
          cnt_d   = lut_cnt_c;
          ps_d    = '0;
          unit_d  = '0;
        end
      end
      MARK: begin
        if (phase_end_c) begin
          if (cnt_q > CW'(1)) begin
            state_d = SPACE;
            pat_d   = {pat_q[2:0], 1'b0};
            cnt_d   = cnt_q - CW'(1);
          end else begin
            state_d = LGAP;
          end
        end
      end
      SPACE: if (phase_end_c) state_d = MARK;
      LGAP: begin
        if (phase_end_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    outs_d = (state_d == MARK);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= IDLE;
      ps_q    <= '0;
      unit_q  <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      outs_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      unit_q  <= unit_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      outs_q  <= outs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign outs = outs_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_morse_tx.sv
// Bench for morse_tx: per-cycle scoreboard of {outs,busy,done} built from a Morse model,
// plus a per-letter table of busy/mark cycle totals. Two instances: 2 ticks/unit and 1 tick/unit.
module tb_morse_tx;

  localparam int DOT  = 1;
  localparam int DASH = 3;
  localparam int SYM  = 1;
  localparam int LTR  = 3;

  typedef struct packed {
    logic o;
    logic b;
    logic d;
  } exp_t;

  typedef struct {
    int code;
    int busy_cyc;
    int mark_cyc;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start1, start2;
  logic [2:0] code1, code2;
  logic       outs1, busy1, done1;
  logic       outs2, busy2, done2;

  int   nerr = 0;
  int   nchk = 0;
  int   cyc  = 0;
  exp_t q1[$];
  exp_t q2[$];
  int   busy_cnt1, mark_cnt1, done_cnt1;
  int   busy_cnt2, mark_cnt2, done_cnt2;
  string letters [8];
  vec_t  tv [8];

  morse_tx #(.TICKS_PER_UNIT(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .code(code2),
    .outs(outs2), .busy(busy2), .done(done2)
  );

  morse_tx #(.TICKS_PER_UNIT(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .code(code1),
    .outs(outs1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int got, int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endfunction

  task automatic add(input int which, input exp_t e);
    if (which == 1) q1.push_back(e);
    else            q2.push_back(e);
  endtask

  // Push the expected per-cycle waveform of one letter; n = number of entries.
  task automatic push_letter(input int which, input int c, output int n);
    string s;
    int    tpu;
    int    len;
    tpu = (which == 1) ? 1 : 2;
    s   = letters[c];
    n   = 0;
    for (int i = 0; i < s.len(); i++) begin
      len = ((s.getc(i) == 8'h2D) ? DASH : DOT) * tpu;
      for (int k = 0; k < len; k++) begin add(which, '{o:1'b1, b:1'b1, d:1'b0}); n++; end
      if (i != s.len() - 1)
        for (int k = 0; k < SYM * tpu; k++) begin add(which, '{o:1'b0, b:1'b1, d:1'b0}); n++; end
    end
    for (int k = 0; k < LTR * tpu; k++) begin add(which, '{o:1'b0, b:1'b1, d:1'b0}); n++; end
    add(which, '{o:1'b0, b:1'b0, d:1'b1});
    n++;
  endtask

  task automatic clear_counts();
    busy_cnt1 = 0; mark_cnt1 = 0; done_cnt1 = 0;
    busy_cnt2 = 0; mark_cnt2 = 0; done_cnt2 = 0;
  endtask

  // Advance to the next falling edge and compare both DUTs against their queues.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    e = '0;
    if (q2.size() > 0) e = q2.pop_front();
    chk("d2_outs", int'(outs2), int'(e.o));
    chk("d2_busy", int'(busy2), int'(e.b));
    chk("d2_done", int'(done2), int'(e.d));
    e = '0;
    if (q1.size() > 0) e = q1.pop_front();
    chk("d1_outs", int'(outs1), int'(e.o));
    chk("d1_busy", int'(busy1), int'(e.b));
    chk("d1_done", int'(done1), int'(e.d));
    busy_cnt1 += int'(busy1); mark_cnt1 += int'(outs1); done_cnt1 += int'(done1);
    busy_cnt2 += int'(busy2); mark_cnt2 += int'(outs2); done_cnt2 += int'(done2);
  endtask

  initial begin
    int n;
    int m;
    letters[0] = ".-";   letters[1] = "-...";
    letters[2] = "-.-."; letters[3] = "-..";
    letters[4] = ".";    letters[5] = "..-.";
    letters[6] = "--.";  letters[7] = "....";
    // Hand-derived totals at 2 ticks/unit: {code, busy cycles, mark cycles}.
    tv[0] = '{0, 16, 8};  tv[1] = '{1, 24, 12};
    tv[2] = '{2, 28, 16}; tv[3] = '{3, 20, 10};
    tv[4] = '{4, 8, 2};   tv[5] = '{5, 24, 12};
    tv[6] = '{6, 24, 14}; tv[7] = '{7, 20, 8};

    resetn = 1'b1;
    start1 = 1'b0; start2 = 1'b0;
    code1  = '0;   code2  = '0;
    clear_counts();
    step();
    step();
    resetn = 1'b0;
    step();

    // Every letter on the 2-tick instance; code is scrambled after acceptance.
    for (int i = 0; i < 8; i++) begin
      clear_counts();
      push_letter(2, tv[i].code, n);
      start2 = 1'b1;
      code2  = 3'(tv[i].code);
      step();
      start2 = 1'b0;
      code2  = 3'($urandom_range(7, 0));
      repeat (n - 1 + 2) step();
      chk("tbl_busy_cycles", busy_cnt2, tv[i].busy_cyc);
      chk("tbl_mark_cycles", mark_cnt2, tv[i].mark_cyc);
      chk("tbl_done_pulses", done_cnt2, 1);
    end

    // H at 1 tick/unit: 4 one-cycle marks, 1-cycle spaces, 3-cycle gap.
    clear_counts();
    push_letter(1, 7, n);
    start1 = 1'b1;
    code1  = 3'd7;
    step();
    start1 = 1'b0;
    repeat (n - 1 + 2) step();
    chk("h_busy_cycles", busy_cnt1, 10);
    chk("h_mark_cycles", mark_cnt1, 4);
    chk("h_done_pulses", done_cnt1, 1);

    // C, then a start for E during C's first mark.
    clear_counts();
    push_letter(2, 2, n);
    start2 = 1'b1;
    code2  = 3'd2;
    step();
    start2 = 1'b0;
    step();
    step();
    start2 = 1'b1;
    code2  = 3'd4;
`ifdef MORSE_TX_QUEUE_EN
    push_letter(2, 4, m);
`else
    m = 0;
`endif
    step();
    start2 = 1'b0;
    code2  = 3'd1;
    repeat (n + m - 4 + 3) step();
`ifdef MORSE_TX_QUEUE_EN
    chk("busy_start_done_pulses", done_cnt2, 2);
    chk("busy_start_mark_cycles", mark_cnt2, 16 + 2);
`else
    chk("busy_start_done_pulses", done_cnt2, 1);
    chk("busy_start_mark_cycles", mark_cnt2, 16);
`endif

    // E, then G requested on E's done cycle: G's first mark follows at once.
    clear_counts();
    push_letter(2, 4, n);
    start2 = 1'b1;
    code2  = 3'd4;
    step();
    start2 = 1'b0;
    repeat (n - 1) step();
    chk("b2b_done_seen", int'(done2), 1);
    start2 = 1'b1;
    code2  = 3'd6;
    push_letter(2, 6, m);
    step();
    start2 = 1'b0;
    chk("b2b_first_mark", int'(outs2), 1);
    repeat (m - 1 + 2) step();
    chk("b2b_done_pulses", done_cnt2, 2);

    // Reset during B's second element: outputs drop without a clock edge.
    clear_counts();
    push_letter(2, 1, n);
    start2 = 1'b1;
    code2  = 3'd1;
    step();
    start2 = 1'b0;
    repeat (8) step();
    chk("rst_pre_outs", int'(outs2), 1);
    #1 resetn = 1'b1;
    #1;
    chk("rst_async_outs", int'(outs2), 0);
    chk("rst_async_busy", int'(busy2), 0);
    chk("rst_async_done", int'(done2), 0);
    q2.delete();
    clear_counts();
    step();
    step();
    chk("rst_no_done", done_cnt2, 0);
    resetn = 1'b0;
    clear_counts();
    push_letter(2, 1, n);
    start2 = 1'b1;
    code2  = 3'd1;
    step();
    start2 = 1'b0;
    repeat (n - 1 + 2) step();
    chk("rst_after_busy_cycles", busy_cnt2, 24);
    chk("rst_after_done_pulses", done_cnt2, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
